median_wr_pingpong: RTL and testbench

// - Parametrised successor of the single-buffer median writer. Accepts median samples and writes them

---
 rtl/median_wr_pingpong_if.sv | 9 +
 rtl/median_wr_pingpong.sv | 177 +++++++++++++++++
 tb/tb_median_wr_pingpong.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_wr_pingpong_if.sv
// Clock/reset bundle for median_wr_pingpong.
// Ports: clk, rstn (async active-low); master drives, slave receives.
interface clk_rst_intrfc;
    logic clk;
    logic rstn;

    modport master (output clk, output rstn);
    modport slave  (input  clk, input  rstn);
endinterface

// File: rtl/median_wr_pingpong.sv
// Ping-pong median writer: fills two BRAM banks alternately, hands
// full banks to the reader with a level req/ack, stalls when both are full.
// Ports: interfc (clk/rstn), median/median_en in, BRAM wr_data/address_wr/wea,
//   rd_req/rd_bank/rd_ack block handshake, fill_cnt, overflow/ovf_clr.
// Option: define MEDIAN_WR_FLUSH_EN to add flush (in) and rd_len (out).
module median_wr_pingpong #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    clk_rst_intrfc.slave      interfc,
    input  logic [DATA_W-1:0] median,
    input  logic              median_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   address_wr,
    output logic              wea,
    output logic              rd_req,
    output logic              rd_bank,
    input  logic              rd_ack,
    output logic [ADDR_W:0]   fill_cnt,
    output logic              overflow,
`ifdef MEDIAN_WR_FLUSH_EN
    input  logic              flush,
    output logic [ADDR_W:0]   rd_len,
`endif
    input  logic              ovf_clr
);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_wr_bank;
    logic [ADDR_W-1:0]   r_idx;
    logic [1:0]          r_pend;
    logic                r_stg_v;
    logic                r_stg_bank;
    logic                r_rd_bank;
    logic                r_ovf;
    logic                r_wea;
    logic [DATA_W-1:0]   r_wr_data;
    logic [ADDR_W:0]     r_addr;

    logic                w_ack_v;
    logic                w_fill;
    logic                w_accept;
    logic                w_last;
    logic                w_close;
    logic                w_target;
    logic                w_tgt_busy;

    logic                w_wea_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [ADDR_W:0]     w_addr_nxt;
    logic [ADDR_W-1:0]   w_idx_nxt;
    logic                w_bank_nxt;
    logic [1:0]          w_pend_nxt;
    logic                w_rd_bank_nxt;
    logic                w_ovf_nxt;

    assign w_ack_v  = rd_ack & (|r_pend);
    assign w_fill   = (r_state == S_FILL);
    assign w_accept = median_en & w_fill;
    assign w_last   = w_accept & (r_idx == ADDR_W'(DEPTH - 1));

`ifdef MEDIAN_WR_FLUSH_EN
    logic [ADDR_W:0]     w_cnt;
    logic [ADDR_W:0]     r_len [2];

    // Count including a sample written in the same cycle as the flush.
    assign w_cnt   = {1'b0, r_idx} + {{ADDR_W{1'b0}}, w_accept};
    assign w_close = w_last | (flush & w_fill & (w_cnt != '0));
    assign rd_len  = r_len[r_rd_bank];

    always_ff @(posedge interfc.clk or negedge interfc.rstn) begin
        if (!interfc.rstn) begin
            r_len[0] <= '0;
            r_len[1] <= '0;
        end else if (w_close) begin
            r_len[r_wr_bank] <= w_cnt;
        end
    end
`else
    assign w_close = w_last;
`endif

    // The bank we switch into must not still be owned by the reader.
    // A closed bank spends one cycle in staging before it is pending,
    // so staging counts as busy; an ack this cycle frees the target.
    assign w_target   = ~r_wr_bank;
    assign w_tgt_busy = (r_pend[w_target] &
                         ~(w_ack_v & (r_rd_bank == w_target))) |
                        (r_stg_v & (r_stg_bank == w_target));

    always_ff @(posedge interfc.clk or negedge interfc.rstn) begin
        if (!interfc.rstn) r_state <= S_FILL;
        else               r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_FILL: begin
                if (w_close && w_tgt_busy) w_state_nxt = S_STALL;
            end
            S_STALL: begin
                if (w_ack_v && (r_rd_bank == r_wr_bank)) w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_comb begin
        w_wea_nxt  = w_accept;
        w_data_nxt = w_accept ? median : '0;
        w_addr_nxt = w_accept ? {r_wr_bank, r_idx} : '0;

        w_idx_nxt  = r_idx;
        w_bank_nxt = r_wr_bank;
        if (w_close) begin
            w_idx_nxt  = '0;
            w_bank_nxt = ~r_wr_bank;
        end else if (w_accept) begin
            w_idx_nxt  = r_idx + ADDR_W'(1);
        end

        w_pend_nxt = r_pend;
        if (w_ack_v) w_pend_nxt[r_rd_bank]  = 1'b0;
        if (r_stg_v) w_pend_nxt[r_stg_bank] = 1'b1;

        // Banks are closed and read strictly in alternation.
        w_rd_bank_nxt = r_rd_bank ^ w_ack_v;

        w_ovf_nxt = r_ovf;
        if (median_en && (r_state == S_STALL)) w_ovf_nxt = 1'b1;
        else if (ovf_clr)                      w_ovf_nxt = 1'b0;
    end

    always_ff @(posedge interfc.clk or negedge interfc.rstn) begin
        if (!interfc.rstn) begin
            r_wr_bank  <= 1'b0;
            r_idx      <= '0;
            r_pend     <= '0;
            r_stg_v    <= 1'b0;
            r_stg_bank <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_ovf      <= 1'b0;
            r_wea      <= 1'b0;
            r_wr_data  <= '0;
            r_addr     <= '0;
        end else begin
            r_wr_bank  <= w_bank_nxt;
            r_idx      <= w_idx_nxt;
            r_pend     <= w_pend_nxt;
            r_stg_v    <= w_close;
            r_stg_bank <= r_wr_bank;
            r_rd_bank  <= w_rd_bank_nxt;
            r_ovf      <= w_ovf_nxt;
            r_wea      <= w_wea_nxt;
            r_wr_data  <= w_data_nxt;
            r_addr     <= w_addr_nxt;
        end
    end

    assign wea        = r_wea;
    assign wr_data    = r_wr_data;
    assign address_wr = r_addr;
    assign rd_req     = |r_pend;
    assign rd_bank    = r_rd_bank;
    assign fill_cnt   = {1'b0, r_idx};
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_median_wr_pingpong.sv
// Bench for median_wr_pingpong: directed scenarios with literal checks
// plus a queue-based bank model compared every cycle.
module tb_median_wr_pingpong;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    clk_rst_intrfc u_if ();

    logic [DATA_W-1:0] median;
    logic              median_en;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   address_wr;
    logic              wea;
    logic              rd_req;
    logic              rd_bank;
    logic              rd_ack;
    logic [ADDR_W:0]   fill_cnt;
    logic              overflow;
    logic              ovf_clr;
    logic              flush;
`ifdef MEDIAN_WR_FLUSH_EN
    logic [ADDR_W:0]   rd_len;
`endif

    median_wr_pingpong #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .interfc    (u_if),
        .median     (median),
        .median_en  (median_en),
        .wr_data    (wr_data),
        .address_wr (address_wr),
        .wea        (wea),
        .rd_req     (rd_req),
        .rd_bank    (rd_bank),
        .rd_ack     (rd_ack),
        .fill_cnt   (fill_cnt),
        .overflow   (overflow),
`ifdef MEDIAN_WR_FLUSH_EN
        .flush      (flush),
        .rd_len     (rd_len),
`endif
        .ovf_clr    (ovf_clr)
    );

    initial u_if.clk = 1'b0;
    always #5 u_if.clk = ~u_if.clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // Model: a bank is a list of samples; closed banks queue up for the reader.
    typedef struct packed {
        logic bank;
        int   len;
    } bk_t;

    bk_t m_q[$];
    bk_t m_stg[$];
    bit  m_bank  = 0;
    int  m_cnt   = 0;
    bit  m_stall = 0;
    bit  m_ovf   = 0;
    int  m_acks  = 0;

    bit  e_wea = 0;
    int  e_data = 0;
    int  e_addr = 0;
    bit  e_req = 0;
    bit  e_rdbank = 0;
    int  e_len = 0;

    bit  t_ack, t_acc, t_cls, t_busy;
    int  t_nc;
    bk_t t_new;

    always @(posedge u_if.clk or negedge u_if.rstn) begin
        if (!u_if.rstn) begin
            m_q.delete();
            m_stg.delete();
            m_bank = 0; m_cnt = 0; m_stall = 0; m_ovf = 0; m_acks = 0;
            e_wea = 0; e_data = 0; e_addr = 0;
        end else begin
            t_ack = rd_ack && (m_q.size() > 0);
            t_acc = median_en && !m_stall;
            t_nc  = m_cnt + (t_acc ? 1 : 0);
            t_cls = (t_nc == DEPTH) || (flush && !m_stall && t_nc > 0);
            e_wea  = t_acc;
            e_data = t_acc ? int'(median) : 0;
            e_addr = t_acc ? (int'(m_bank) * DEPTH + m_cnt) : 0;
            if (median_en && m_stall) m_ovf = 1;
            else if (ovf_clr)         m_ovf = 0;
            if (t_ack) begin
                void'(m_q.pop_front());
                m_acks++;
                if (m_stall) m_stall = 0;
            end
            t_busy = 0;
            foreach (m_q[k])   if (m_q[k].bank == !m_bank)   t_busy = 1;
            foreach (m_stg[k]) if (m_stg[k].bank == !m_bank) t_busy = 1;
            foreach (m_stg[k]) m_q.push_back(m_stg[k]);
            m_stg.delete();
            if (t_cls) begin
                if (t_busy) m_stall = 1;
                t_new.bank = m_bank;
                t_new.len  = t_nc;
                m_stg.push_back(t_new);
                m_bank = !m_bank;
                m_cnt  = 0;
            end else begin
                m_cnt = t_nc;
            end
        end
        e_req    = (m_q.size() > 0);
        e_rdbank = m_acks[0];
        e_len    = (m_q.size() > 0) ? m_q[0].len : 0;
    end

    always @(negedge u_if.clk) begin
        if (chk_en) begin
            chk("m_wea", wea, e_wea);
            chk("m_wr_data", wr_data, e_data);
            if (e_wea) chk("m_addr", address_wr, e_addr);
            chk("m_rd_req", rd_req, e_req);
            if (e_req) chk("m_rd_bank", rd_bank, e_rdbank);
            chk("m_fill_cnt", fill_cnt, m_cnt);
            chk("m_overflow", overflow, m_ovf);
`ifdef MEDIAN_WR_FLUSH_EN
            if (e_req) chk("m_rd_len", rd_len, e_len);
`endif
        end
    end

    task automatic step(input bit en, input logic [15:0] d, input bit ack,
                        input bit fl, input bit clr);
        median_en = en;
        median    = d;
        rd_ack    = ack;
        flush     = fl;
        ovf_clr   = clr;
        @(posedge u_if.clk);
        #1;
        median_en = 0;
        median    = '0;
        rd_ack    = 0;
        flush     = 0;
        ovf_clr   = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wea"}, wea, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_addr"}, address_wr, 0);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_rd_bank"}, rd_bank, 0);
        chk({tag, "_fill_cnt"}, fill_cnt, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        u_if.rstn = 1; median_en = 0; median = '0;
        rd_ack = 0; flush = 0; ovf_clr = 0;
        #3 u_if.rstn = 0;
        chk_en = 1;
        #1 chk_zero("rst");
        repeat (3) @(posedge u_if.clk);
        #1 u_if.rstn = 1;

        // Bank 0: eight back-to-back samples.
        for (int i = 0; i < 8; i++) begin
            step(1, 16'(i + 1), 0, 0, 0);
            chk("t1_wea", wea, 1);
            chk("t1_addr", address_wr, i);
            chk("t1_data", wr_data, i + 1);
        end
        chk("t1_req_early", rd_req, 0);
        step(0, 0, 0, 0, 0);
        chk("t1_req", rd_req, 1);
        chk("t1_rd_bank", rd_bank, 0);

        // Bank 1 without ack, then a dropped sample.
        for (int i = 8; i < 16; i++) begin
            step(1, 16'(i + 1), 0, 0, 0);
            chk("t2_addr", address_wr, i);
        end
        step(1, 16'h0011, 0, 0, 0);
        chk("t2_wea_stall", wea, 0);
        chk("t2_ovf", overflow, 1);
        step(1, 16'h0012, 0, 0, 1);
        chk("t2_ovf_setwins", overflow, 1);
        step(0, 0, 0, 0, 1);
        chk("t2_ovf_clr", overflow, 0);

        // Ack out of stall.
        step(0, 0, 1, 0, 0);
        chk("t3_req_held", rd_req, 1);
        chk("t3_rd_bank", rd_bank, 1);
        step(1, 16'h0021, 0, 0, 0);
        chk("t3_wea", wea, 1);
        chk("t3_addr", address_wr, 0);

        // Ack coincident with the last sample of bank 1.
        step(0, 0, 1, 0, 0);
        chk("t4_req_low", rd_req, 0);
        for (int i = 1; i < 8; i++) step(1, 16'(16'h0100 + i), 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 16'(16'h0200 + i), 0, 0, 0);
        step(1, 16'h0207, 1, 0, 0);
        chk("t4_addr15", address_wr, 15);
        chk("t4_rd_bank", rd_bank, 1);
        step(1, 16'h0031, 0, 0, 0);
        chk("t4_nostall_wea", wea, 1);
        chk("t4_nostall_addr", address_wr, 0);
        chk("t4_req", rd_req, 1);
        chk("t4_rd_bank2", rd_bank, 1);

        // Reset in the middle of a bank.
        for (int i = 0; i < 4; i++) step(1, 16'(16'h0300 + i), 0, 0, 0);
        chk("t5_fill5", fill_cnt, 5);
        #2 u_if.rstn = 0;
        #1 chk_zero("t5");
        repeat (2) @(posedge u_if.clk);
        #2 u_if.rstn = 1;
        step(1, 16'h0041, 0, 0, 0);
        chk("t5_wea", wea, 1);
        chk("t5_addr", address_wr, 0);

`ifdef MEDIAN_WR_FLUSH_EN
        // Early close after three samples.
        step(1, 16'h0042, 0, 0, 0);
        step(1, 16'h0043, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("t6_req_early", rd_req, 0);
        step(1, 16'h0055, 0, 0, 0);
        chk("t6_addr8", address_wr, 8);
        chk("t6_req", rd_req, 1);
        chk("t6_rd_len", rd_len, 3);
`endif

        // Mixed traffic checked against the model only.
        for (int i = 0; i < 300; i++) begin
            step((i % 4) != 3, 16'(i * 37 + 5),
                 (i < 150) ? ((i % 23) == 6) : ((i % 9) == 2),
`ifdef MEDIAN_WR_FLUSH_EN
                 (i % 13) == 4,
`else
                 1'b0,
`endif
                 (i % 17) == 0);
        end
        repeat (3) @(posedge u_if.clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
